// File: rtl/pc_update_unit.sv
// Program-counter stage of the multi-cycle MIPS datapath: holds PC and EPC,
// selects the next PC, flags misaligned targets and counts taken branches.
module pc_update_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PCWrite,
   input  logic             PCWriteCond,
   input  logic             branch_cond,
   input  logic [2:0]       PCSource,
   input  logic [31:0]      alu_result,
   input  logic [31:0]      alu_out,
   input  logic [25:0]      jump_target,
   input  logic [31:0]      reg_rs,
   input  logic [31:0]      exc_vector,
   input  logic             EPCWrite,
   output logic [31:0]      pc,
   output logic [31:0]      epc,
   output logic             pc_written,
   output logic             pc_misaligned,
   output logic [CNT_W-1:0] branch_taken_cnt
);

   logic [31:0]      r_pc;
   logic [31:0]      r_epc;
   logic             r_pc_written;
   logic             r_pc_misaligned;
   logic [CNT_W-1:0] r_cnt;

   logic        w_pc_req;
   logic        w_source_valid;
   logic [31:0] w_next_pc;
   logic        w_aligned;
   logic        w_do_write;
   logic        w_count;

   assign w_pc_req = PCWrite | (PCWriteCond & branch_cond);

   always_comb begin
      w_next_pc      = 32'h0000_0000;
      w_source_valid = 1'b1;
      case (PCSource)
         3'b000:  w_next_pc = alu_result;
         3'b001:  w_next_pc = alu_out;
         // r_pc already holds PC+4 by the time a jump executes
         3'b010:  w_next_pc = {r_pc[31:28], jump_target, 2'b00};
         3'b011:  w_next_pc = reg_rs;
         3'b100:  w_next_pc = exc_vector;
         3'b101:  w_next_pc = r_epc;
         default: w_source_valid = 1'b0;
      endcase
   end

   assign w_aligned  = (w_next_pc[1:0] == 2'b00);
   assign w_do_write = w_pc_req & w_source_valid & w_aligned;
   assign w_count    = w_do_write & PCWriteCond & branch_cond & (r_cnt != {CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc            <= RESET_PC;
         r_epc           <= 32'h0000_0000;
         r_pc_written    <= 1'b0;
         r_pc_misaligned <= 1'b0;
         r_cnt           <= '0;
      end else begin
         r_pc_written    <= w_do_write;
         r_pc_misaligned <= w_pc_req & w_source_valid & ~w_aligned;
         if (w_do_write)
            r_pc <= w_next_pc;
         // Same-cycle EPCWrite with PCSource=101 lets the PC take the old EPC
         if (EPCWrite)
            r_epc <= alu_result;
         if (w_count)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign pc               = r_pc;
   assign epc              = r_epc;
   assign pc_written       = r_pc_written;
   assign pc_misaligned    = r_pc_misaligned;
   assign branch_taken_cnt = r_cnt;

endmodule

// File: tb/tb_pc_update_unit.sv
// Randomized bench for pc_update_unit: a behavioural model tracks PC/EPC/counter
// every cycle, and a short directed sequence pins the model with literal values.
module tb_pc_update_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          CNT_W    = 3;
   localparam int          CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             PCWrite, PCWriteCond, branch_cond, EPCWrite;
   logic [2:0]       PCSource;
   logic [31:0]      alu_result, alu_out, reg_rs, exc_vector;
   logic [25:0]      jump_target;
   logic [31:0]      pc, epc;
   logic             pc_written, pc_misaligned;
   logic [CNT_W-1:0] branch_taken_cnt;

   int tests = 0;
   int fails = 0;

   // Reference state
   logic [31:0] m_pc, m_epc;
   logic        m_wr, m_mis;
   int          m_cnt;
   bit          m_valid = 1'b0;

   pc_update_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .branch_cond(branch_cond), .PCSource(PCSource), .alu_result(alu_result),
      .alu_out(alu_out), .jump_target(jump_target), .reg_rs(reg_rs),
      .exc_vector(exc_vector), .EPCWrite(EPCWrite), .pc(pc), .epc(epc),
      .pc_written(pc_written), .pc_misaligned(pc_misaligned),
      .branch_taken_cnt(branch_taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails < 30)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: evaluate one clock edge from the inputs present before it
   always @(posedge clk) begin
      logic        req, ok;
      logic [31:0] tgt;
      req = PCWrite | (PCWriteCond & branch_cond);
      ok  = 1'b1;
      tgt = 32'h0;
      if (PCSource == 3'd0)      tgt = alu_result;
      else if (PCSource == 3'd1) tgt = alu_out;
      else if (PCSource == 3'd2) tgt = (m_pc & 32'hF000_0000) | (32'(jump_target) * 4);
      else if (PCSource == 3'd3) tgt = reg_rs;
      else if (PCSource == 3'd4) tgt = exc_vector;
      else if (PCSource == 3'd5) tgt = m_epc;
      else                       ok  = 1'b0;
      if (reset === 1'b1) begin
         m_pc = RESET_PC; m_epc = 0; m_wr = 0; m_mis = 0; m_cnt = 0; m_valid = 1'b1;
      end else if (m_valid) begin
         m_wr  = req && ok && (tgt % 4 == 0);
         m_mis = req && ok && (tgt % 4 != 0);
         if (m_wr && PCWriteCond && branch_cond && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         if (m_wr) m_pc = tgt;
         if (EPCWrite) m_epc = alu_result;
      end
      #1;
      if (m_valid) begin
         check("model_pc", pc, m_pc);
         check("model_epc", epc, m_epc);
         check("model_written", 32'(pc_written), 32'(m_wr));
         check("model_misaligned", 32'(pc_misaligned), 32'(m_mis));
         check("model_cnt", 32'(branch_taken_cnt), 32'(m_cnt));
      end
   end

   task automatic idle();
      reset = 0; PCWrite = 0; PCWriteCond = 0; branch_cond = 0; EPCWrite = 0;
      PCSource = 3'd0; alu_result = 0; alu_out = 0; jump_target = 0;
      reg_rs = 0; exc_vector = 0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      idle();
      reset = 1;
      tick(); tick();
      reset = 0;
      check("reset_pc", pc, RESET_PC);
      check("reset_epc", epc, 32'h0);
      check("reset_cnt", 32'(branch_taken_cnt), 32'h0);
      check("reset_written", 32'(pc_written), 32'h0);
      $display("[TB] reset: pc=%h epc=%h cnt=%0d", pc, epc, branch_taken_cnt);

      PCWrite = 1; PCSource = 3'd0; alu_result = 32'h4;
      tick();
      check("fetch_pc", pc, 32'h4);
      check("fetch_written", 32'(pc_written), 32'h1);
      check("fetch_cnt", 32'(branch_taken_cnt), 32'h0);
      idle(); tick();
      check("fetch_pulse_end", 32'(pc_written), 32'h0);
      $display("[TB] fetch: pc=%h", pc);

      PCWriteCond = 1; branch_cond = 0; PCSource = 3'd1; alu_out = 32'h40;
      tick();
      check("br_not_taken_pc", pc, 32'h4);
      branch_cond = 1;
      tick();
      check("br_taken_pc", pc, 32'h40);
      check("br_taken_cnt", 32'(branch_taken_cnt), 32'h1);
      $display("[TB] branch: pc=%h cnt=%0d", pc, branch_taken_cnt);

      idle(); PCWrite = 1; PCSource = 3'd3; reg_rs = 32'hA000_0010;
      tick();
      PCSource = 3'd2; jump_target = 26'h0000100;
      tick();
      check("jump_pc", pc, 32'hA000_0400);
      $display("[TB] jump: pc=%h", pc);

      idle(); PCWrite = 1; PCSource = 3'd3; reg_rs = 32'h0000_0102;
      tick();
      check("misal_pc", pc, 32'hA000_0400);
      check("misal_flag", 32'(pc_misaligned), 32'h1);
      check("misal_written", 32'(pc_written), 32'h0);
      idle(); tick();
      check("misal_pulse_end", 32'(pc_misaligned), 32'h0);
      $display("[TB] misaligned: pc=%h", pc);

      EPCWrite = 1; alu_result = 32'h20; PCWrite = 1; PCSource = 3'd4; exc_vector = 32'h80;
      tick();
      check("exc_epc", epc, 32'h20);
      check("exc_pc", pc, 32'h80);
      alu_result = 32'h44; PCSource = 3'd5;
      tick();
      check("eret_pc_old_epc", pc, 32'h20);
      check("eret_epc_new", epc, 32'h44);
      $display("[TB] exception/eret: pc=%h epc=%h", pc, epc);

      idle(); PCWrite = 1; PCSource = 3'd6;
      tick();
      check("invalid_src_pc", pc, 32'h20);
      check("invalid_src_flags", {30'h0, pc_written, pc_misaligned}, 32'h0);

      for (int k = 1; k <= CNT_MAX + 1; k++) begin
         idle(); PCWriteCond = 1; branch_cond = 1; PCWrite = k[0];
         PCSource = 3'd1; alu_out = 32'h100 + 32'(k) * 4;
         tick();
         check("sat_cnt", 32'(branch_taken_cnt), (k + 1 > CNT_MAX) ? CNT_MAX : k + 1);
         $display("[TB] taken branch %0d: cnt=%0d", k, branch_taken_cnt);
      end
      idle(); PCWrite = 1; PCSource = 3'd0; alu_result = 32'h200;
      tick();
      check("pcwrite_no_count", 32'(branch_taken_cnt), CNT_MAX);

      reset = 1; alu_result = 32'h8; PCWriteCond = 1; branch_cond = 1;
      tick();
      check("midreset_pc", pc, RESET_PC);
      check("midreset_cnt", 32'(branch_taken_cnt), 32'h0);
      check("midreset_written", 32'(pc_written), 32'h0);
      $display("[TB] mid-op reset: pc=%h cnt=%0d", pc, branch_taken_cnt);

      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 99) == 0);
         PCWrite     = ($urandom_range(0, 3) == 0);
         PCWriteCond = ($urandom_range(0, 1) == 0);
         branch_cond = $urandom_range(0, 1);
         EPCWrite    = ($urandom_range(0, 4) == 0);
         PCSource    = 3'($urandom_range(0, 7));
         alu_result  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         alu_out     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         reg_rs      = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         exc_vector  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         jump_target = 26'($urandom);
         tick();
         if (n % 500 == 0)
            $display("[TB] random %0d: pc=%h epc=%h cnt=%0d", n, pc, epc, branch_taken_cnt);
      end

      idle(); tick(); tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
